// File: rtl/pkt_arb_pkg.sv
// Shared types and default sizing for the packet ingress arbiter.
package pkt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W    = 32;   // parser data_in width
  localparam int DEF_PKT_WORDS = 24;   // 768-bit frame / 32-bit words
  localparam int DEF_TIMEOUT   = 64;   // stall cycles tolerated while a packet is open

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N.
module rr_pick
  import pkt_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Scan ptr+1, ptr+2, ... ptr+N; the first set request wins, ptr itself is checked last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_ingress_arbiter.sv
// Packet-level round-robin arbiter in front of the parser input. A grant is held
// for a whole packet; length checking and a stall watchdog force closure so a
// misbehaving source cannot wedge the parser path.
module pkt_ingress_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PKT_WORDS = DEF_PKT_WORDS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_last,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        m_valid,
  output logic [DATA_W-1:0]           m_data,
  input  logic                        m_ready,
  output logic [NUM_SRC-1:0]          grant,
  output logic [$clog2(NUM_SRC)-1:0]  grant_id,
  output logic                        busy,
  output logic                        pkt_done,
  output logic                        err_length,
  output logic                        err_timeout
);

  localparam int ID_W = $clog2(NUM_SRC);
  localparam int WC_W = $clog2(PKT_WORDS);
  localparam int SC_W = $clog2(TIMEOUT);

  localparam logic [WC_W-1:0] LAST_IDX  = WC_W'(PKT_WORDS - 1);
  localparam logic [SC_W-1:0] STALL_MAX = SC_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] PTR_INIT  = ID_W'(NUM_SRC - 1);

  arb_state_t      state;
  logic [WC_W-1:0] word_cnt;
  logic [SC_W-1:0] stall_cnt;
  logic [ID_W-1:0] rr_ptr;

  logic [NUM_SRC-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  logic cur_last;
  logic beat;
  logic close_done;
  logic close_len;
  logic close_to;
  logic close_pkt;

  rr_pick #(
    .N (NUM_SRC)
  ) u_pick (
    .req    (src_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Zero-latency pass-through from the owning source; everything held at 0 while idle.
  always_comb begin
    src_ready = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    cur_last  = 1'b0;
    if (busy) begin
      m_valid             = src_valid[grant_id];
      m_data              = src_data[int'(grant_id)*DATA_W +: DATA_W];
      cur_last            = src_last[grant_id];
      src_ready[grant_id] = m_ready;
    end
  end

  assign beat = m_valid & m_ready;

  // Close decisions: the length check only looks at beats, and a beat always beats the watchdog.
  always_comb begin
    close_done = 1'b0;
    close_len  = 1'b0;
    close_to   = 1'b0;
    if (state == BUSY) begin
      if (beat) begin
        if (word_cnt == LAST_IDX) begin
          close_done = cur_last;
          close_len  = ~cur_last;
        end else begin
          close_len  = cur_last;
        end
      end else begin
        close_to = (stall_cnt == STALL_MAX);
      end
    end
  end

  assign close_pkt = close_done | close_len | close_to;

  // Arbitration / packet-tracking FSM with registered grant and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
      err_length  <= 1'b0;
      err_timeout <= 1'b0;
      word_cnt    <= '0;
      stall_cnt   <= '0;
      rr_ptr      <= PTR_INIT;
    end else begin
      pkt_done    <= close_done;
      err_length  <= close_len;
      err_timeout <= close_to;
      case (state)
        IDLE: begin
          word_cnt  <= '0;
          stall_cnt <= '0;
          if (pick_any) begin
            state    <= BUSY;
            grant    <= pick_onehot;
            grant_id <= pick_idx;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (close_pkt) begin
            // The closing owner becomes lowest priority for the next round.
            state     <= IDLE;
            grant     <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            word_cnt  <= '0;
            stall_cnt <= '0;
            rr_ptr    <= grant_id;
          end else if (beat) begin
            word_cnt  <= word_cnt + 1'b1;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pkt_ingress_arbiter.md
Name: pkt_ingress_arbiter

Overview:
Packet-level round-robin arbiter that shares the single 32-bit parser input (data_in / parser_valid_in / parser_ready_in) between NUM_SRC packet sources. A grant is held for a whole packet of PKT_WORDS words (24 words = 768-bit eth+ip+tcp+payload frame), so the parser never sees interleaved packets. Per-packet length checking and a stall watchdog release a misbehaving source without hanging the parser/FIFO path. Sits between the source ports and top's parser input.

Parameters:
NUM_SRC, 4, number of requesting sources (>=2)
DATA_W, 32, word width, equal to parser data_in width
PKT_WORDS, 24, words per packet (768/32)
TIMEOUT, 64, max consecutive no-beat cycles while a packet is open

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
src_valid  in  NUM_SRC  per-source word valid
src_data  in  NUM_SRC*DATA_W  per-source word; source i at [i*DATA_W +: DATA_W]
src_last  in  NUM_SRC  per-source last-word marker
src_ready  out  NUM_SRC  per-source accept; only the granted bit can be 1
m_valid  out  1  to parser_valid_in
m_data  out  DATA_W  to data_in
m_ready  in  1  from parser_ready_in
grant  out  NUM_SRC  one-hot current owner, 0 when idle
grant_id  out  $clog2(NUM_SRC)  encoded owner, valid while busy
busy  out  1  packet open
pkt_done  out  1  1-cycle pulse: packet closed normally
err_length  out  1  1-cycle pulse: last/count mismatch
err_timeout  out  1  1-cycle pulse: watchdog fired

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE, grant=0, grant_id=0, busy=0, pulses 0, word_cnt=0, stall_cnt=0, rr_ptr=NUM_SRC-1 (source 0 wins first). src_ready, m_valid, m_data=0 combinationally when idle. Reset mid-packet aborts it silently (no error pulse).
- Beat = m_valid && m_ready. In BUSY: m_valid=src_valid[grant_id], m_data=src_data[grant_id], src_ready[grant_id]=m_ready, all other src_ready=0. Combinational pass-through, zero latency.
- FSM IDLE: if any src_valid, pick first requester searching rr_ptr+1, rr_ptr+2, ... (mod NUM_SRC); register grant/grant_id, busy=1, go BUSY. Arbitration costs one cycle; no beat in IDLE. src_last is ignored in IDLE.
- FSM BUSY: each beat word_cnt++, stall_cnt cleared. Close conditions, checked on a beat:
  - word_cnt==PKT_WORDS-1 and src_last=1 -> pkt_done pulse.
  - word_cnt==PKT_WORDS-1 and src_last=0 -> err_length pulse (packet closed at fixed length).
  - word_cnt<PKT_WORDS-1 and src_last=1 -> err_length pulse (short packet closed).
- Watchdog: no beat in a BUSY cycle -> stall_cnt++; on stall_cnt reaching TIMEOUT-1 with no beat -> err_timeout pulse, close. A beat in that same cycle wins (no timeout).
- Close: next cycle state IDLE, grant=0, busy=0, word_cnt=0, stall_cnt=0, rr_ptr=closing grant_id. Minimum one idle bubble between packets; a closed source re-requesting immediately loses to any other requester.
- Pulses are registered, asserted in the cycle after the closing beat/timeout, exactly one cycle; at most one of the three per packet.
- Counters: word_cnt width $clog2(PKT_WORDS), stall_cnt width $clog2(TIMEOUT); neither wraps (closure precedes overflow).
- src_valid deasserting mid-packet is legal (stall, counted by watchdog). Non-granted sources' valid/last have no effect.

Decomposition:
- Package pkt_arb_pkg: state enum {IDLE, BUSY}, PKT_WORDS/TIMEOUT defaults, DATA_W.
- Sub-module rr_pick: combinational round-robin picker (req vector, rr_ptr -> one-hot + encoded winner + any).

Test Plan:
- Source 0 sends 24-word test1 frame (A1../B2../C3../D4F40099.., last on word 24) with m_ready=1 -> grant=0001 one cycle after first valid, 24 beats, pkt_done pulse once, parser FIFO holds identical words.
- Sources 0,1,2 all request continuously, 24-word packets -> grant order 0,1,2,0,... with one idle cycle between packets, no interleaved words.
- Source 1 asserts src_last on word 10 -> err_length pulse, busy drops, next requester granted; 24 words without last -> err_length after word 24.
- Granted source drops src_valid after word 5 for 64 cycles (TIMEOUT=64) -> err_timeout pulse cycle after 64th stall cycle, grant released; at 63 stall cycles then a beat -> no error.
- m_ready held low 10 cycles mid-packet by parser with src_valid=1 -> src_ready=0, no beats, no timeout, transfer resumes, word_cnt unchanged.
- rst=1 asserted at word 12 of a packet -> next cycle all outputs 0, no pulses; after release source 0 is granted first.
